// File: rtl/tetris_move_if.sv
// Signal bundle between the move controller and its board-level surroundings.
// Buttons are raw asynchronous levels; all outputs are registered or decoded from registered state.
interface tetris_move_if;
    logic [3:0] button;
    logic [3:0] bled;
    logic [3:0] rled;
    logic [3:0] gled;
    logic       landed;
    logic       blocked;
    logic [7:0] land_count;
    logic [1:0] state_dbg;

    modport master (
        output button,
        input  bled, rled, gled, landed, blocked, land_count, state_dbg
    );

    modport slave (
        input  button,
        output bled, rled, gled, landed, blocked, land_count, state_dbg
    );
endinterface

// File: rtl/tetris_move_ctrl.sv
// Move controller for a 12-cell one-hot piece: debounced buttons plus gravity drops,
// one bounds-checked move per cycle, and a LAND/SPAWN sequence when the piece reaches row 0.
module tetris_move_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 10,
    parameter int          DROP_PERIOD     = 1_000_000,
    parameter logic [11:0] SPAWN_POS       = 12'h100
) (
    input logic          clk,
    input logic          rst,
    tetris_move_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAND  = 2'd1,
        ST_SPAWN = 2'd2
    } state_t;

    localparam int            GW      = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;
    localparam logic [GW-1:0] G_LAST  = GW'(DROP_PERIOD - 1);
    localparam logic [GW-1:0] G_ONE   = GW'(1);
    localparam logic [4:0]    DB_LAST = 5'(DEBOUNCE_CYCLES - 1);

    // Pending-bit indices; a higher index wins arbitration.
    localparam int P_UP    = 0;
    localparam int P_RIGHT = 1;
    localparam int P_LEFT  = 2;
    localparam int P_DOWN  = 3;
    localparam int P_DROP  = 4;

    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    deb_q, deb_d, rise;
    logic [4:0]    db_cnt_q [4];
    logic [4:0]    db_cnt_d [4];
    state_t        state_q, state_d;
    logic [11:0]   pos_q, pos_d;
    logic [4:0]    pend_q, pend_d, grant, btn_req;
    logic [GW-1:0] grav_q, grav_d;
    logic          grav_tick;
    logic          blocked_q, blocked_d;
    logic [7:0]    land_cnt_q, land_cnt_d;
    logic          at_col3, at_col0, at_row2, at_row0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.button;
            sync2_q <= sync1_q;
        end
    end

    // Counter tracks how long the synced level has disagreed with the debounced one.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 5'd1;
                end
            end
        end
        rise = deb_d & ~deb_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign at_col3 = |(pos_q & 12'h888);
    assign at_col0 = |(pos_q & 12'h111);
    assign at_row2 = |pos_q[11:8];
    assign at_row0 = |pos_q[3:0];

    always_comb begin
        btn_req          = '0;
        btn_req[P_RIGHT] = rise[0];
        btn_req[P_DOWN]  = rise[1];
        btn_req[P_UP]    = rise[2];
        btn_req[P_LEFT]  = rise[3];
    end

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        pend_d     = pend_q;
        grav_d     = grav_q;
        land_cnt_d = land_cnt_q;
        blocked_d  = 1'b0;
        grav_tick  = 1'b0;
        grant      = '0;
        case (state_q)
            ST_IDLE: begin
                if (grav_q == G_LAST) begin
                    grav_d    = '0;
                    grav_tick = 1'b1;
                end else begin
                    grav_d = grav_q + G_ONE;
                end
                if (pend_q[P_DROP])       grant[P_DROP]  = 1'b1;
                else if (pend_q[P_DOWN])  grant[P_DOWN]  = 1'b1;
                else if (pend_q[P_LEFT])  grant[P_LEFT]  = 1'b1;
                else if (pend_q[P_RIGHT]) grant[P_RIGHT] = 1'b1;
                else if (pend_q[P_UP])    grant[P_UP]    = 1'b1;

                if (grant[P_DROP] || grant[P_DOWN]) begin
                    if (at_row0) state_d = ST_LAND;
                    else         pos_d   = pos_q >> 4;
                end else if (grant[P_LEFT]) begin
                    if (at_col3) blocked_d = 1'b1;
                    else         pos_d     = pos_q << 1;
                end else if (grant[P_RIGHT]) begin
                    if (at_col0) blocked_d = 1'b1;
                    else         pos_d     = pos_q >> 1;
                end else if (grant[P_UP]) begin
                    if (at_row2) blocked_d = 1'b1;
                    else         pos_d     = pos_q << 4;
                end
                // Requests coalesce: setting an already-set bit loses the new one.
                pend_d         = (pend_q & ~grant) | btn_req;
                pend_d[P_DROP] = pend_d[P_DROP] | grav_tick;
            end
            ST_LAND: begin
                pos_d      = '0;
                land_cnt_d = land_cnt_q + 8'd1;
                state_d    = ST_SPAWN;
            end
            ST_SPAWN: begin
                pos_d   = SPAWN_POS;
                grav_d  = '0;
                pend_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pos_q      <= SPAWN_POS;
            pend_q     <= '0;
            grav_q     <= '0;
            blocked_q  <= 1'b0;
            land_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            pend_q     <= pend_d;
            grav_q     <= grav_d;
            blocked_q  <= blocked_d;
            land_cnt_q <= land_cnt_d;
        end
    end

    assign bus.bled       = pos_q[11:8];
    assign bus.rled       = pos_q[7:4];
    assign bus.gled       = pos_q[3:0];
    assign bus.landed     = (state_q == ST_LAND);
    assign bus.blocked    = blocked_q;
    assign bus.land_count = land_cnt_q;
    assign bus.state_dbg  = state_q;
endmodule
